// File: rtl/parking_keypad_entry.sv
// Keypad front end for the parking gate controller.
// Debounces a raw key strobe, collects two 2-bit digits, offers them to the
// gate controller with a valid/ready handshake, then acts on the GREEN/RED
// verdict. The verdict can finish the entry, start a retry, or lock the keypad out.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | no session; waiting for car_present
// DIG1  | waiting for the first digit (per-digit timeout running)
// DIG2  | waiting for the second digit (per-digit timeout running)
// SEND  | password offered with pw_valid, held until pw_ready
// WAIT  | password transferred, waiting for the gate verdict
// LOCK  | too many RED verdicts; keypad ignored for LOCKOUT_CYCLES
module parking_keypad_entry #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int TIMEOUT_CYCLES  = 1000,
    parameter int MAX_TRIES       = 3,
    parameter int LOCKOUT_CYCLES  = 500,
    parameter int CNT_W           = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       car_present,
    input  logic       key_press,
    input  logic [1:0] key_code,
    input  logic       pw_ready,
    input  logic       gate_green,
    input  logic       gate_red,
    output logic [1:0] password_1,
    output logic [1:0] password_2,
    output logic       pw_valid,
    output logic [1:0] tries,
    output logic       lockout,
    output logic       timeout_p
);

    // The debounce counter only has to reach DEBOUNCE_CYCLES-1.
    localparam int DB_W = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES);
    localparam logic [DB_W-1:0]  DB_LAST      = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] LOCK_LAST    = CNT_W'(LOCKOUT_CYCLES - 1);
    localparam logic [1:0]       TRIES_MAX    = 2'(MAX_TRIES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DIG1,
        S_DIG2,
        S_SEND,
        S_WAIT,
        S_LOCK
    } state_t;

    state_t           state, next_state;
    logic [CNT_W-1:0] timer, next_timer;
    logic [1:0]       next_pw1, next_pw2, next_tries, tries_inc;
    logic             next_valid, next_lock, next_to;

    logic             db_pressed;
    logic [DB_W-1:0]  db_cnt;
    logic             key_accept;

    // The press is accepted on the DEBOUNCE_CYCLES-th consecutive high sample.
    // It is a combinational strobe, so key_code is captured in that same cycle.
    assign key_accept = key_press && !db_pressed && (db_cnt == DB_LAST);

    assign tries_inc = (tries == TRIES_MAX) ? tries : tries + 2'd1;

    // Debounce: count consecutive samples that disagree with the debounced level.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            db_pressed <= 1'b0;
            db_cnt     <= '0;
        end else if (key_press == db_pressed) begin
            db_cnt <= '0;
        end else if (db_cnt == DB_LAST) begin
            db_pressed <= key_press;
            db_cnt     <= '0;
        end else begin
            db_cnt <= db_cnt + DB_W'(1);
        end
    end

    // State, timer and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            timer      <= '0;
            password_1 <= '0;
            password_2 <= '0;
            pw_valid   <= 1'b0;
            tries      <= '0;
            lockout    <= 1'b0;
            timeout_p  <= 1'b0;
        end else begin
            state      <= next_state;
            timer      <= next_timer;
            password_1 <= next_pw1;
            password_2 <= next_pw2;
            pw_valid   <= next_valid;
            tries      <= next_tries;
            lockout    <= next_lock;
            timeout_p  <= next_to;
        end
    end

    // Next-state and next-output logic. The timer defaults to 0, so every state
    // entry starts it from zero and it can never wrap.
    always_comb begin
        next_state = state;
        next_timer = '0;
        next_pw1   = password_1;
        next_pw2   = password_2;
        next_valid = pw_valid;
        next_tries = tries;
        next_lock  = lockout;
        next_to    = 1'b0;

        case (state)
            S_IDLE: begin
                if (car_present) begin
                    next_state = S_DIG1;
                end
            end

            S_DIG1, S_DIG2: begin
                if (!car_present) begin
                    next_state = S_IDLE;
                    next_pw1   = '0;
                    next_pw2   = '0;
                    next_valid = 1'b0;
                    next_tries = '0;
                end else if (key_accept) begin
                    if (state == S_DIG1) begin
                        next_pw1   = key_code;
                        next_state = S_DIG2;
                    end else begin
                        next_pw2   = key_code;
                        next_state = S_SEND;
                        next_valid = 1'b1;
                    end
                end else if (timer == TIMEOUT_LAST) begin
                    next_to    = 1'b1;
                    next_state = S_IDLE;
                    next_pw1   = '0;
                    next_pw2   = '0;
                end else begin
                    next_timer = timer + CNT_W'(1);
                end
            end

            S_SEND: begin
                if (!car_present) begin
                    next_state = S_IDLE;
                    next_pw1   = '0;
                    next_pw2   = '0;
                    next_valid = 1'b0;
                    next_tries = '0;
                end else if (pw_ready) begin
                    next_state = S_WAIT;
                    next_valid = 1'b0;
                end
            end

            S_WAIT: begin
                // A simultaneous GREEN and RED is treated as GREEN.
                if (gate_green) begin
                    next_state = S_IDLE;
                    next_tries = '0;
                end else if (gate_red) begin
                    next_tries = tries_inc;
                    if (tries_inc == TRIES_MAX) begin
                        next_state = S_LOCK;
                        next_lock  = 1'b1;
                    end else begin
                        next_state = S_DIG1;
                    end
                end
            end

            S_LOCK: begin
                if (timer == LOCK_LAST) begin
                    next_state = S_IDLE;
                    next_tries = '0;
                    next_lock  = 1'b0;
                end else begin
                    next_timer = timer + CNT_W'(1);
                end
            end

            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_parking_keypad_entry.sv
// Bench for parking_keypad_entry: directed scenarios, a behavioural model
// checked every cycle, and hand-computed literal expectations.
module tb_parking_keypad_entry;

    localparam int DEB   = 3;
    localparam int TO    = 50;
    localparam int MAXT  = 3;
    localparam int LOCKC = 20;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       car_present = 1'b0;
    logic       key_press = 1'b0;
    logic [1:0] key_code = 2'd0;
    logic       pw_ready = 1'b0;
    logic       gate_green = 1'b0;
    logic       gate_red = 1'b0;
    logic [1:0] password_1, password_2, tries;
    logic       pw_valid, lockout, timeout_p;

    int checks = 0;
    int failures = 0;

    parking_keypad_entry #(
        .DEBOUNCE_CYCLES(DEB),
        .TIMEOUT_CYCLES (TO),
        .MAX_TRIES      (MAXT),
        .LOCKOUT_CYCLES (LOCKC),
        .CNT_W          (16)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .car_present(car_present),
        .key_press  (key_press),
        .key_code   (key_code),
        .pw_ready   (pw_ready),
        .gate_green (gate_green),
        .gate_red   (gate_red),
        .password_1 (password_1),
        .password_2 (password_2),
        .pw_valid   (pw_valid),
        .tries      (tries),
        .lockout    (lockout),
        .timeout_p  (timeout_p)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    localparam int M_IDLE = 0, M_DIG1 = 1, M_DIG2 = 2, M_SEND = 3, M_WAIT = 4, M_LOCK = 5;
    int phase = M_IDLE;
    int age = 0;
    int hi_run = 0, lo_run = 0;
    bit held = 0;
    bit accept;
    int e_pw1 = 0, e_pw2 = 0, e_valid = 0, e_tries = 0, e_lock = 0, e_to = 0;

    task automatic clear_session();
        phase = M_IDLE; e_pw1 = 0; e_pw2 = 0; e_valid = 0; e_tries = 0;
    endtask

    always @(posedge clk) begin
        if (reset) begin
            phase = M_IDLE; age = 0; hi_run = 0; lo_run = 0; held = 0;
            e_pw1 = 0; e_pw2 = 0; e_valid = 0; e_tries = 0; e_lock = 0; e_to = 0;
        end else begin
            if (key_press) begin hi_run++; lo_run = 0; end
            else begin lo_run++; hi_run = 0; end
            accept = 0;
            if (!held && hi_run == DEB) begin accept = 1; held = 1; end
            else if (held && lo_run == DEB) held = 0;
            e_to = 0;
            case (phase)
                M_IDLE: if (car_present) begin phase = M_DIG1; age = 0; end
                M_DIG1, M_DIG2: begin
                    if (!car_present) clear_session();
                    else if (accept) begin
                        age = 0;
                        if (phase == M_DIG1) begin e_pw1 = key_code; phase = M_DIG2; end
                        else begin e_pw2 = key_code; phase = M_SEND; e_valid = 1; end
                    end else begin
                        age++;
                        if (age == TO) begin e_to = 1; phase = M_IDLE; e_pw1 = 0; e_pw2 = 0; end
                    end
                end
                M_SEND: begin
                    if (!car_present) clear_session();
                    else if (pw_ready) begin phase = M_WAIT; e_valid = 0; end
                end
                M_WAIT: begin
                    if (gate_green) begin phase = M_IDLE; e_tries = 0; end
                    else if (gate_red) begin
                        if (e_tries < MAXT) e_tries++;
                        age = 0;
                        if (e_tries == MAXT) begin phase = M_LOCK; e_lock = 1; end
                        else phase = M_DIG1;
                    end
                end
                M_LOCK: begin
                    age++;
                    if (age == LOCKC) begin phase = M_IDLE; e_tries = 0; e_lock = 0; end
                end
                default: phase = M_IDLE;
            endcase
        end
        #1;
        chk("model_pw_valid",  32'(pw_valid),   32'(e_valid));
        chk("model_password_1", 32'(password_1), 32'(e_pw1));
        chk("model_password_2", 32'(password_2), 32'(e_pw2));
        chk("model_tries",     32'(tries),      32'(e_tries));
        chk("model_lockout",   32'(lockout),    32'(e_lock));
        chk("model_timeout_p", 32'(timeout_p),  32'(e_to));
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input logic [1:0] code, input int hi, input int lo);
        key_code  = code;
        key_press = 1'b1;
        tick(hi);
        key_press = 1'b0;
        tick(lo);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lock_cnt, to_cnt, to_first;
        logic [1:0] to_pw1, to_pw2;

        tick(2);
        reset = 1'b0;
        tick(1);
        chk("reset_pw_valid", 32'(pw_valid), 0);
        chk("reset_tries", 32'(tries), 0);
        chk("reset_lockout", 32'(lockout), 0);
        chk("reset_password_1", 32'(password_1), 0);

        // Normal entry 1,2 then GREEN.
        car_present = 1'b1;
        tick(2);
        press(2'd1, 3, 3);
        press(2'd2, 3, 0);
        chk("entry_pw_valid", 32'(pw_valid), 1);
        chk("entry_password_1", 32'(password_1), 1);
        chk("entry_password_2", 32'(password_2), 2);
        key_press = 1'b0;
        pw_ready = 1'b1;
        tick(1);
        pw_ready = 1'b0;
        chk("transfer_pw_valid_drop", 32'(pw_valid), 0);
        gate_green = 1'b1;
        car_present = 1'b0;
        tick(1);
        gate_green = 1'b0;
        tick(3);
        chk("green_tries", 32'(tries), 0);

        // Glitch ignored, long hold gives one digit, then pw_ready held low.
        car_present = 1'b1;
        tick(2);
        key_code = 2'd1;
        key_press = 1'b1;
        tick(2);
        key_press = 1'b0;
        tick(3);
        press(2'd3, 10, 3);
        press(2'd2, 3, 0);
        chk("hold_pw_valid", 32'(pw_valid), 1);
        chk("hold_password_1", 32'(password_1), 3);
        chk("hold_password_2", 32'(password_2), 2);
        key_press = 1'b0;
        tick(30);
        chk("stall_pw_valid", 32'(pw_valid), 1);
        chk("stall_password_1", 32'(password_1), 3);
        chk("stall_password_2", 32'(password_2), 2);

        // Three RED verdicts lead to lockout.
        pw_ready = 1'b1; tick(1); pw_ready = 1'b0;
        gate_red = 1'b1; tick(1); gate_red = 1'b0;
        chk("red1_tries", 32'(tries), 1);
        press(2'd1, 3, 3);
        press(2'd1, 3, 3);
        pw_ready = 1'b1; tick(1); pw_ready = 1'b0;
        gate_red = 1'b1; tick(1); gate_red = 1'b0;
        chk("red2_tries", 32'(tries), 2);
        press(2'd1, 3, 3);
        press(2'd1, 3, 3);
        pw_ready = 1'b1; tick(1); pw_ready = 1'b0;
        gate_red = 1'b1;
        car_present = 1'b0;
        tick(1);
        gate_red = 1'b0;
        chk("red3_tries", 32'(tries), 3);
        chk("red3_lockout", 32'(lockout), 1);
        lock_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (lockout) lock_cnt++;
            key_code  = 2'd3;
            key_press = ((i % 8) < 4);
            tick(1);
        end
        key_press = 1'b0;
        tick(4);
        chk("lockout_length", 32'(lock_cnt), LOCKC);
        chk("post_lock_tries", 32'(tries), 0);
        chk("post_lock_lockout", 32'(lockout), 0);
        chk("lock_presses_ignored", 32'(password_1), 1);

        // Digit timeout in DIG1.
        to_cnt = 0;
        to_first = -1;
        to_pw1 = 2'd3;
        to_pw2 = 2'd3;
        car_present = 1'b1;
        for (int i = 0; i < 70; i++) begin
            tick(1);
            if (timeout_p) begin
                if (to_first < 0) begin
                    to_first = i;
                    to_pw1 = password_1;
                    to_pw2 = password_2;
                end
                to_cnt++;
            end
        end
        car_present = 1'b0;
        tick(2);
        chk("timeout_count", 32'(to_cnt), 1);
        chk("timeout_cycle", 32'(to_first), 50);
        chk("timeout_password_1", 32'(to_pw1), 0);
        chk("timeout_password_2", 32'(to_pw2), 0);

        // car_present drops in DIG2.
        car_present = 1'b1;
        tick(2);
        press(2'd2, 3, 3);
        chk("dig2_password_1", 32'(password_1), 2);
        car_present = 1'b0;
        tick(1);
        chk("drop_password_1", 32'(password_1), 0);
        chk("drop_pw_valid", 32'(pw_valid), 0);
        tick(5);

        // Asynchronous reset while offering a password.
        car_present = 1'b1;
        tick(2);
        press(2'd1, 3, 3);
        press(2'd3, 3, 3);
        chk("presend_pw_valid", 32'(pw_valid), 1);
        #2 reset = 1'b1;
        #1;
        chk("async_reset_pw_valid", 32'(pw_valid), 0);
        chk("async_reset_password_1", 32'(password_1), 0);
        chk("async_reset_password_2", 32'(password_2), 0);
        chk("async_reset_tries", 32'(tries), 0);
        chk("async_reset_lockout", 32'(lockout), 0);
        chk("async_reset_timeout_p", 32'(timeout_p), 0);
        @(negedge clk);
        reset = 1'b0;
        car_present = 1'b0;
        tick(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
